// File: rtl/alu_operand_sequencer_pkg.sv
// rtl/alu_operand_sequencer_pkg.sv - shared opcodes, state encodings and ALU timing for the operand sequencer
package alu_operand_sequencer_pkg;

    localparam logic OP_NOT = 1'b0;
    localparam logic OP_ADD = 1'b1;

    localparam int ALU_LATENCY = 1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD_B  = 3'd1,
        ST_ISSUE   = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_OUT     = 3'd4
    } state_e;

endpackage

// File: rtl/alu_operand_sequencer.sv
// rtl/alu_operand_sequencer.sv - serial operand loader, ALU issue/capture FSM and result port
module alu_operand_sequencer
    import alu_operand_sequencer_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    input  logic         in_op,
    output logic         alu_op_code,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    input  logic [N-1:0] alu_q,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [N-1:0] res_data,
    output logic         res_op,
    output logic         busy,
    output logic [7:0]   txn_count
);

    state_e       state_q, state_d;
    logic         op_q, op_d;
    logic [N-1:0] a_q, a_d;
    logic [N-1:0] b_q, b_d;
    logic [N-1:0] res_data_q, res_data_d;
    logic         res_op_q, res_op_d;
    logic         res_valid_q, res_valid_d;
    logic [7:0]   txn_q, txn_d;
    logic [1:0]   wait_q, wait_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            op_q        <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            res_data_q  <= '0;
            res_op_q    <= 1'b0;
            res_valid_q <= 1'b0;
            txn_q       <= 8'd0;
            wait_q      <= 2'd0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_data_q  <= res_data_d;
            res_op_q    <= res_op_d;
            res_valid_q <= res_valid_d;
            txn_q       <= txn_d;
            wait_q      <= wait_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        res_data_d  = res_data_q;
        res_op_d    = res_op_q;
        res_valid_d = res_valid_q;
        txn_d       = txn_q;
        wait_d      = wait_q;

        case (state_q)
            ST_IDLE: begin
                // b is cleared so a NOT leaves a defined value on the unused operand
                if (in_valid) begin
                    a_d     = in_data;
                    op_d    = in_op;
                    b_d     = '0;
                    state_d = (in_op == OP_NOT) ? ST_ISSUE : ST_LOAD_B;
                end
            end
            ST_LOAD_B: begin
                if (in_valid) begin
                    b_d     = in_data;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // operands stay parked until the ALU pipeline has had time to produce q
                if (wait_q == 2'(ALU_LATENCY - 1)) begin
                    wait_d  = 2'd0;
                    state_d = ST_CAPTURE;
                end else begin
                    wait_d = wait_q + 2'd1;
                end
            end
            ST_CAPTURE: begin
                res_data_d  = alu_q;
                res_op_d    = op_q;
                res_valid_d = 1'b1;
                state_d     = ST_OUT;
            end
            ST_OUT: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    txn_d       = txn_q + 8'd1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                res_valid_d = 1'b0;
                wait_d      = 2'd0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    assign in_ready    = (state_q == ST_IDLE) || (state_q == ST_LOAD_B);
    assign busy        = (state_q != ST_IDLE);
    assign alu_op_code = op_q;
    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign res_valid   = res_valid_q;
    assign res_data    = res_data_q;
    assign res_op      = res_op_q;
    assign txn_count   = txn_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// tb/tb_alu_operand_sequencer.sv - self-checking bench for alu_operand_sequencer with a behavioural ALU
module tb_alu_operand_sequencer;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] in_data = '0;
    logic         in_op = 1'b0;
    logic         alu_op_code;
    logic [N-1:0] alu_a;
    logic [N-1:0] alu_b;
    logic [N-1:0] alu_q = '0;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [N-1:0] res_data;
    logic         res_op;
    logic         busy;
    logic [7:0]   txn_count;

    alu_operand_sequencer #(.N(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_op       (in_op),
        .alu_op_code (alu_op_code),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_q       (alu_q),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_op      (res_op),
        .busy        (busy),
        .txn_count   (txn_count)
    );

    always #5 clk = ~clk;

    // registered two-function ALU with c_in tied to 0
    always @(posedge clk) begin
        alu_q <= alu_op_code ? (alu_a + alu_b) : ~alu_a;
    end

    typedef struct {
        logic         op;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] exp;
    } vec_t;

    typedef struct {
        logic [N-1:0] data;
        logic         op;
    } exp_t;

    vec_t       vecs[6];
    exp_t       sb_q[$];
    int         pass_cnt = 0;
    int         total_cnt = 0;
    logic [7:0] exp_txn = 8'd0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && res_valid && res_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_result", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("res_data", 32'(res_data), 32'(e.data));
                check("res_op", 32'(res_op), 32'(e.op));
            end
        end
    end

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        res_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb_q.delete();
        exp_txn = 8'd0;
    endtask

    task automatic send_word(input logic [N-1:0] d, input logic op);
        bit done = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_op    = op;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (in_ready) done = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_res_valid(output int lat);
        lat = 0;
        while (!res_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!res_valid) check("res_valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20 && busy; i++) begin
            @(posedge clk);
            #1;
        end
        if (busy) check("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic run_txn(input logic op, input logic [N-1:0] a, input logic [N-1:0] b,
                           input logic [N-1:0] exp, input bit chk_lat);
        int lat;
        sb_q.push_back('{data: exp, op: op});
        res_ready = 1'b1;
        send_word(a, op);
        if (op) send_word(b, 1'b0);
        wait_res_valid(lat);
        if (chk_lat) check("latency", 32'(lat), 32'd2);
        wait_idle();
        exp_txn = exp_txn + 8'd1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;

        vecs[0] = '{op: 1'b1, a: 8'h12, b: 8'h34, exp: 8'h46};
        vecs[1] = '{op: 1'b1, a: 8'hFF, b: 8'h02, exp: 8'h01};
        vecs[2] = '{op: 1'b0, a: 8'hA5, b: 8'h00, exp: 8'h5A};
        vecs[3] = '{op: 1'b0, a: 8'h00, b: 8'h00, exp: 8'hFF};
        vecs[4] = '{op: 1'b1, a: 8'h80, b: 8'h80, exp: 8'h00};
        vecs[5] = '{op: 1'b0, a: 8'hFF, b: 8'h00, exp: 8'h00};

        do_reset();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_alu_op_code", 32'(alu_op_code), 32'd0);
        check("rst_alu_a", 32'(alu_a), 32'd0);
        check("rst_alu_b", 32'(alu_b), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_data", 32'(res_data), 32'd0);
        check("rst_res_op", 32'(res_op), 32'd0);
        check("rst_txn_count", 32'(txn_count), 32'd0);

        for (int i = 0; i < 6; i++) begin
            run_txn(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, 1'b1);
            check("vec_alu_a", 32'(alu_a), 32'(vecs[i].a));
            check("vec_alu_b", 32'(alu_b), vecs[i].op ? 32'(vecs[i].b) : 32'd0);
            check("vec_alu_op_code", 32'(alu_op_code), 32'(vecs[i].op));
            check("vec_txn_count", 32'(txn_count), 32'(exp_txn));
            check("vec_in_ready", 32'(in_ready), 32'd1);
        end

        // backpressure: result held, input stalled, no word stolen
        res_ready = 1'b0;
        sb_q.push_back('{data: 8'h2F, op: 1'b1});
        send_word(8'h20, 1'b1);
        send_word(8'h0F, 1'b0);
        wait_res_valid(lat);
        check("bp_latency", 32'(lat), 32'd2);
        in_valid = 1'b1;
        in_data  = 8'h77;
        in_op    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_res_data", 32'(res_data), 32'h2F);
            check("bp_res_valid", 32'(res_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_txn_count", 32'(txn_count), 32'(exp_txn));
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        res_ready = 1'b1;
        wait_idle();
        exp_txn = exp_txn + 8'd1;
        check("bp_txn_after", 32'(txn_count), 32'(exp_txn));
        check("bp_alu_a_kept", 32'(alu_a), 32'h20);
        check("bp_alu_b_kept", 32'(alu_b), 32'h0F);

        // reset while waiting for operand B
        res_ready = 1'b1;
        send_word(8'h10, 1'b1);
        check("mid_busy", 32'(busy), 32'd1);
        check("mid_alu_a", 32'(alu_a), 32'h10);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        exp_txn = 8'd0;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_alu_a", 32'(alu_a), 32'd0);
        check("mid_rst_alu_op", 32'(alu_op_code), 32'd0);
        check("mid_rst_txn", 32'(txn_count), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        check("mid_no_result", 32'(res_valid), 32'd0);
        run_txn(1'b1, 8'h01, 8'h01, 8'h02, 1'b1);
        check("mid_after_txn", 32'(txn_count), 32'd1);

        // counter wrap over 256 NOT transactions
        do_reset();
        for (int i = 0; i < 255; i++) begin
            logic [N-1:0] d;
            d = 8'(i);
            run_txn(1'b0, d, 8'h00, ~d, 1'b0);
        end
        check("wrap_before", 32'(txn_count), 32'hFF);
        run_txn(1'b0, 8'h3C, 8'h00, 8'hC3, 1'b1);
        check("wrap_after", 32'(txn_count), 32'h00);

        repeat (2) @(posedge clk);
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
